button_switch_input: RTL and testbench

Memory-mapped input peripheral for the board-level MIPS top. It is the read path that complements the seven-segment output path. It synchronises and debounces the L/R push-buttons and synchronises the 16 slide switches. It latches button presses as sticky pending flags with press counters and exposes everything to the CPU through a 4-word register window: combinational read, write-1-to-clear.

---
 rtl/button_switch_input.sv | 112 +++++++++++
 tb/tb_button_switch_input.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/button_switch_input.sv
// L/R push-button and slide-switch input window: two-flop synchronisers, per-button
// debounce, sticky press flags with 8-bit press counters, combinational register read.
module button_switch_input #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SW_WIDTH        = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                L,
  input  logic                R,
  input  logic [SW_WIDTH-1:0] SW,
  input  logic [3:0]          addr,
  input  logic                we,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata
);
  localparam int          SYNC_W   = SW_WIDTH + 2;
  localparam logic [7:0]  CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] ID_VALUE = 32'h1A0B_0001;

  logic [SYNC_W-1:0]   r_sync_p0;
  logic [SYNC_W-1:0]   r_sync_p1;
  logic [1:0]          r_db;
  logic [7:0]          r_deb_cnt [2];
  logic [1:0]          r_pend;
  logic [7:0]          r_press_cnt [2];

  logic [1:0]          w_btn_s;
  logic [SW_WIDTH-1:0] w_sw_s;
  logic [1:0]          w_press;
  logic [1:0]          w_pend_clr;
  logic                w_wr_status;
  logic                w_wr_count;
  logic                w_unused_bits;

  // Stage p0/p1: two-flop synchronisers, bit order {SW, R, L}
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync_p0 <= '0;
      r_sync_p1 <= '0;
    end else begin
      r_sync_p0 <= {SW, R, L};
      r_sync_p1 <= r_sync_p0;
    end
  end

  assign w_btn_s = r_sync_p1[1:0];
  assign w_sw_s  = r_sync_p1[SYNC_W-1:2];

  // A press is the edge on which a rising level completes its qualification run
  always_comb begin
    w_press = '0;
    for (int i = 0; i < 2; i++) begin
      w_press[i] = w_btn_s[i] && !r_db[i] && (r_deb_cnt[i] == CNT_LAST);
    end
  end

  // Debounce: a new level must be seen on DEBOUNCE_CYCLES consecutive samples
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_db         <= '0;
      r_deb_cnt[0] <= '0;
      r_deb_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_btn_s[i] == r_db[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == CNT_LAST) begin
          r_db[i]      <= w_btn_s[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + 8'd1;
        end
      end
    end
  end

  assign w_wr_status = we && (addr[3:2] == 2'd0);
  assign w_wr_count  = we && (addr[3:2] == 2'd2);
  assign w_pend_clr  = {2{w_wr_status}} & wdata[1:0];

  // A press on the same edge as a clear takes priority in both flags and counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend         <= '0;
      r_press_cnt[0] <= '0;
      r_press_cnt[1] <= '0;
    end else begin
      r_pend <= (r_pend & ~w_pend_clr) | w_press;
      for (int i = 0; i < 2; i++) begin
        if (w_press[i]) begin
          r_press_cnt[i] <= w_wr_count ? 8'd1 : r_press_cnt[i] + 8'd1;
        end else if (w_wr_count) begin
          r_press_cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (addr[3:2])
      2'd0:    rdata = {28'd0, r_db[1], r_db[0], r_pend[1], r_pend[0]};
      2'd1:    rdata = 32'(w_sw_s);
      2'd2:    rdata = {16'd0, r_press_cnt[1], r_press_cnt[0]};
      default: rdata = ID_VALUE;
    endcase
  end

  assign w_unused_bits = ^{wdata[31:2], addr[1:0]};

endmodule

// File: tb/tb_button_switch_input.sv
// Randomized bench for button_switch_input against a history-based reference model.
module tb_button_switch_input;
  localparam int D   = 4;
  localparam int SWW = 16;
  localparam logic [255:0] MASK = (256'd1 << D) - 256'd1;

  logic           clk = 1'b0;
  logic           reset;
  logic           L;
  logic           R;
  logic [SWW-1:0] SW;
  logic [3:0]     addr;
  logic           we;
  logic [31:0]    wdata;
  logic [31:0]    rdata;

  always #10 clk = ~clk;

  button_switch_input #(.DEBOUNCE_CYCLES(D), .SW_WIDTH(SWW)) dut (
    .clk(clk), .reset(reset), .L(L), .R(R), .SW(SW),
    .addr(addr), .we(we), .wdata(wdata), .rdata(rdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Reference: raw inputs as sampled on each edge, two edges of delay, and a window
  // of samples seen since reset or since the last accepted level change.
  logic [SWW+1:0] m_sync1, m_sync2;
  logic [255:0]   m_hist [2];
  int             m_len  [2];
  logic [1:0]     m_db, m_pend;
  logic [7:0]     m_cnt  [2];

  task automatic model_reset();
    m_sync1 = '0; m_sync2 = '0; m_db = '0; m_pend = '0;
    for (int b = 0; b < 2; b++) begin
      m_hist[b] = '0; m_len[b] = 0; m_cnt[b] = '0;
    end
  endtask

  task automatic model_edge();
    logic [1:0] s, press, clr;
    logic       cnt_clr;
    s = m_sync2[1:0];
    press = '0;
    for (int b = 0; b < 2; b++) begin
      m_hist[b] = {m_hist[b][254:0], s[b]};
      if (m_len[b] < 256) m_len[b]++;
      if (m_len[b] >= D && (m_hist[b] & MASK) == (m_db[b] ? 256'd0 : MASK)) begin
        press[b] = !m_db[b];
        m_db[b]  = !m_db[b];
        m_len[b] = 0;
      end
    end
    clr     = (we && addr[3:2] == 2'd0) ? wdata[1:0] : 2'b00;
    cnt_clr = we && addr[3:2] == 2'd2;
    m_pend  = (m_pend & ~clr) | press;
    for (int b = 0; b < 2; b++) begin
      if (cnt_clr) m_cnt[b] = 8'd0;
      if (press[b]) m_cnt[b] = m_cnt[b] + 8'd1;
    end
    m_sync2 = m_sync1;
    m_sync1 = {SW, R, L};
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] a);
    case (a[3:2])
      2'd0:    return {28'd0, m_db[1], m_db[0], m_pend[1], m_pend[0]};
      2'd1:    return {16'd0, m_sync2[SWW+1:2]};
      2'd2:    return {16'd0, m_cnt[1], m_cnt[0]};
      default: return 32'h1A0B_0001;
    endcase
  endfunction

  task automatic sweep(input string ph);
    for (int k = 0; k < 4; k++) begin
      addr = 4'(k * 4 + int'($urandom_range(0, 3)));
      #1;
      check_eq($sformatf("%s_reg%0d", ph, k), rdata, model_read(addr));
    end
  endtask

  // Drive one cycle's inputs (called just after a falling edge), clock, then check.
  task automatic cycle(input logic l, input logic r, input logic [SWW-1:0] sw,
                       input logic w, input logic [3:0] a, input logic [31:0] d);
    L = l; R = r; SW = sw; we = w; addr = a; wdata = d;
    @(posedge clk);
    if (reset) model_edge();
    #1;
    we = 1'b0;
    sweep("cyc");
    @(negedge clk);
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rdata;
  endtask

  // One clean press of the selected buttons; optional store lands on the press edge.
  task automatic press(input logic [1:0] btn, input logic w, input logic [3:0] a,
                       input logic [31:0] d, input logic [SWW-1:0] sw);
    for (int n = 1; n <= 8; n++) cycle(btn[0], btn[1], sw, w && n == 2 + D, a, d);
    for (int n = 0; n < 8; n++) cycle(1'b0, 1'b0, sw, 1'b0, 4'd0, 32'd0);
  endtask

  logic [31:0]    v;
  logic [SWW-1:0] cur_sw;
  logic           rl, rr;
  int             lat;

  initial begin
    reset = 1'b0; L = 1'b1; R = 1'b1; SW = 16'h1234; we = 1'b0; addr = 4'd0; wdata = '0;
    model_reset();
    cur_sw = 16'h1234;
    @(negedge clk);
    for (int n = 0; n < 10; n++) cycle(1'b1, 1'b1, cur_sw, 1'b0, 4'd0, 32'd0);
    rd(4'd0, v);  check_eq("rst_status", v, 32'd0);
    rd(4'd8, v);  check_eq("rst_count", v, 32'd0);
    rd(4'd12, v); check_eq("rst_id", v, 32'h1A0B_0001);

    @(negedge clk);
    reset = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      cycle(1'b1, 1'b1, cur_sw, 1'b0, 4'd0, 32'd0);
      if (n == 1) begin rd(4'd4, v); check_eq("sw_lat1", v, 32'd0); end
      if (n == 2) begin rd(4'd4, v); check_eq("sw_lat2", v, 32'h0000_1234); end
      if (n == 5) begin rd(4'd0, v); check_eq("st_lat5", v, 32'd0); end
      if (n == 6) begin
        rd(4'd0, v); check_eq("st_lat6", v, 32'h0000_000F);
        rd(4'd8, v); check_eq("cnt_first", v, 32'h0000_0101);
      end
    end

    // Clean R press held 25 cycles while L released
    for (int n = 0; n < 8; n++) cycle(1'b0, 1'b1, cur_sw, 1'b0, 4'd0, 32'd0);
    cycle(1'b0, 1'b0, cur_sw, 1'b1, 4'd0, 32'd3);
    cycle(1'b0, 1'b0, cur_sw, 1'b1, 4'd8, 32'd0);
    for (int n = 0; n < 8; n++) cycle(1'b0, 1'b0, cur_sw, 1'b0, 4'd0, 32'd0);
    for (int n = 0; n < 25; n++) cycle(1'b0, 1'b1, cur_sw, 1'b0, 4'd0, 32'd0);
    rd(4'd0, v); check_eq("r_held", v, 32'h0000_0A);
    for (int n = 0; n < 10; n++) cycle(1'b0, 1'b0, cur_sw, 1'b0, 4'd0, 32'd0);
    rd(4'd0, v); check_eq("r_released", v, 32'h0000_0002);
    rd(4'd8, v); check_eq("r_count", v, 32'h0000_0100);

    // Glitches of 3 samples never qualify, a 10-cycle hold gives one press
    cycle(1'b0, 1'b0, cur_sw, 1'b1, 4'd0, 32'd3);
    cycle(1'b0, 1'b0, cur_sw, 1'b1, 4'd8, 32'd0);
    for (int g = 0; g < 4; g++) begin
      for (int n = 0; n < 3; n++) cycle(1'b1, 1'b0, cur_sw, 1'b0, 4'd0, 32'd0);
      for (int n = 0; n < 3; n++) cycle(1'b0, 1'b0, cur_sw, 1'b0, 4'd0, 32'd0);
    end
    rd(4'd0, v); check_eq("glitch_status", v, 32'd0);
    rd(4'd8, v); check_eq("glitch_count", v, 32'd0);
    for (int n = 0; n < 10; n++) cycle(1'b1, 1'b0, cur_sw, 1'b0, 4'd0, 32'd0);
    for (int n = 0; n < 8; n++) cycle(1'b0, 1'b0, cur_sw, 1'b0, 4'd0, 32'd0);
    rd(4'd8, v); check_eq("hold_count", v, 32'h0000_0001);

    // Write-1-to-clear, and set winning over a same-edge clear
    press(2'b11, 1'b0, 4'd0, 32'd0, cur_sw);
    rd(4'd0, v); check_eq("pend_both", v, 32'h0000_0003);
    cycle(1'b0, 1'b0, cur_sw, 1'b1, 4'd0, 32'd1);
    rd(4'd0, v); check_eq("w1c_l", v, 32'h0000_0002);
    cycle(1'b0, 1'b0, cur_sw, 1'b1, 4'd0, 32'hFFFF_FFFC);
    rd(4'd0, v); check_eq("w1c_none", v, 32'h0000_0002);
    cycle(1'b0, 1'b0, cur_sw, 1'b1, 4'd0, 32'd2);
    press(2'b10, 1'b1, 4'd0, 32'd2, cur_sw);
    rd(4'd0, v); check_eq("set_beats_clr", v, 32'h0000_0002);

    // 256 L presses wrap the counter; a count clear on a press edge leaves 1
    cycle(1'b0, 1'b0, cur_sw, 1'b1, 4'd8, 32'd0);
    for (int p = 0; p < 256; p++) press(2'b01, 1'b0, 4'd0, 32'd0, cur_sw);
    rd(4'd8, v); check_eq("wrap_lcnt", {24'd0, v[7:0]}, 32'd0);
    rd(4'd0, v); check_eq("wrap_lpend", {31'd0, v[0]}, 32'd1);
    press(2'b01, 1'b1, 4'd8, 32'd0, cur_sw);
    rd(4'd8, v); check_eq("clr_on_press", v, 32'h0000_0001);

    // Random levels, switches and stores
    rl = 1'b0; rr = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) rl = ~rl;
      if ($urandom_range(0, 3) == 0) rr = ~rr;
      if (n % 8 == 0) cur_sw = 16'($urandom);
      cycle(rl, rr, cur_sw, $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)), $urandom);
    end

    // Reset part-way through a debounce run, L held through release
    for (int n = 0; n < 8; n++) cycle(1'b0, 1'b0, cur_sw, 1'b0, 4'd0, 32'd0);
    for (int n = 0; n < 4; n++) cycle(1'b1, 1'b0, cur_sw, 1'b0, 4'd0, 32'd0);
    reset = 1'b0;
    model_reset();
    #1;
    sweep("async_rst");
    @(negedge clk);
    for (int n = 0; n < 3; n++) cycle(1'b1, 1'b0, cur_sw, 1'b0, 4'd0, 32'd0);
    reset = 1'b1;
    lat = 0;
    for (int n = 1; n <= 12; n++) begin
      cycle(1'b1, 1'b0, cur_sw, 1'b0, 4'd0, 32'd0);
      rd(4'd0, v);
      if (v[0] && lat == 0) lat = n;
    end
    check_eq("rst_release_latency", lat, 2 + D);
    rd(4'd8, v); check_eq("rst_release_count", v, 32'h0000_0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
